// File: rtl/cp0_unit.sv
// System coprocessor 0: SR/Cause/EPC/PRId, trap request generation and
// eret support for the M stage of the P7 MIPS pipeline.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h2019_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_victim_pc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  // Live HWInt feeds the request; IP is only the software-visible snapshot.
  assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
  assign w_req     = w_int_req | w_exc_req;

  // A delay-slot victim restarts at its branch.
  assign w_victim_pc = BDIn ? (VPC - 32'd4) : VPC;

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        // The victim's own mtc0 is flushed, so WE is dropped here.
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
        r_bd      <= BDIn;
        r_epc     <= {w_victim_pc[31:2], 2'b00};
      end else begin
        if (WE && (A2 == REG_SR)) begin
          r_im  <= DIn[15:10];
          r_exl <= DIn[1];
          r_ie  <= DIn[0];
        end
        if (WE && (A2 == REG_EPC))
          r_epc <= {DIn[31:2], 2'b00};
        // Later assignment: eret beats an mtc0 to SR for the EXL bit.
        if (EXLClr)
          r_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = w_sr;
      REG_CAUSE: DOut = w_cause;
      REG_EPC:   DOut = r_epc;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

  assign Req    = w_req;
  assign EPCOut = r_epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed vector table, hand sequences, then random
// cycles checked against a word-level model of the CP0 registers.
module tb_cp0_unit;
  localparam logic [31:0] PRID = 32'h2019_0007;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2, ExcCodeIn;
  logic [31:0] DIn, VPC;
  logic        WE, BDIn, EXLClr;
  logic [5:0]  HWInt;
  logic        Req;
  logic [31:0] EPCOut, DOut;

  cp0_unit #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .Req(Req), .EPCOut(EPCOut), .DOut(DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, we;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [4:0]  a1;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        ereq;
    logic [31:0] eepc, edout;
  } vec_t;

  vec_t tbl[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference state as whole architectural words
  logic [31:0] sr_m, cause_m, epc_m;

  function automatic vec_t mk(input logic [31:0] rst, we, a2, din, a1, vpc,
                              bd, exc, hw, clr, ereq, eepc, edout);
    vec_t v;
    v.rst = rst[0]; v.we = we[0]; v.a2 = a2[4:0]; v.din = din;
    v.a1 = a1[4:0]; v.vpc = vpc; v.bd = bd[0]; v.exc = exc[4:0];
    v.hw = hw[5:0]; v.clr = clr[0]; v.ereq = ereq[0];
    v.eepc = eepc; v.edout = edout;
    return v;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return sr_m;
      5'd13:   return cause_m;
      5'd14:   return epc_m;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int(input vec_t v);
    return ((v.hw & sr_m[15:10]) != 6'd0) && sr_m[0] && !sr_m[1];
  endfunction

  function automatic logic m_req(input vec_t v);
    return m_int(v) || ((v.exc != 5'd0) && !sr_m[1]);
  endfunction

  task automatic m_step(input vec_t v);
    logic [31:0] pc;
    logic [31:0] code;
    if (v.rst) begin
      sr_m = 0; cause_m = 0; epc_m = 0;
    end else if (m_req(v)) begin
      code    = m_int(v) ? 32'd0 : 32'(v.exc);
      cause_m = (32'(v.bd) << 31) | (32'(v.hw) << 10) | (code << 2);
      pc      = v.bd ? v.vpc - 32'd4 : v.vpc;
      epc_m   = pc & ~32'd3;
      sr_m    = sr_m | 32'd2;
    end else begin
      cause_m = (cause_m & ~(32'h3F << 10)) | (32'(v.hw) << 10);
      if (v.we && v.a2 == 5'd12) sr_m  = v.din & 32'h0000_FC03;
      if (v.we && v.a2 == 5'd14) epc_m = v.din & ~32'd3;
      if (v.clr)                 sr_m  = sr_m & ~32'd2;
    end
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, want %h", name, row, act, exp);
    end
  endtask

  // mode 0: no check, 1: table expectations, 2: reference model
  task automatic cyc(input vec_t v, input int mode, input int row);
    reset = v.rst; WE = v.we; A2 = v.a2; DIn = v.din; A1 = v.a1;
    VPC = v.vpc; BDIn = v.bd; ExcCodeIn = v.exc; HWInt = v.hw; EXLClr = v.clr;
    #5;
    if (mode == 1) begin
      chk("req",  row, {31'd0, Req}, {31'd0, v.ereq});
      chk("epc",  row, EPCOut, v.eepc);
      chk("dout", row, DOut, v.edout);
    end else if (mode == 2) begin
      chk("rnd_req",  row, {31'd0, Req}, {31'd0, m_req(v)});
      chk("rnd_epc",  row, EPCOut, epc_m);
      chk("rnd_dout", row, DOut, m_read(v.a1));
    end
    @(posedge clk);
    m_step(v);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [31:0] r;
    reset = 1'b1; WE = 1'b0; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; VPC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    sr_m = 0; cause_m = 0; epc_m = 0;

    //          rst we a2 din            a1 vpc            bd exc hw clr req epc            dout
    // reset state
    tbl.push_back(mk(0, 0, 0, 0,             12, 0,             0, 0,  0, 0, 0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,             15, 0,             0, 0,  0, 0, 0, 0,             PRID));
    tbl.push_back(mk(0, 0, 0, 0,             13, 0,             0, 0,  0, 0, 0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,             14, 0,             0, 0,  0, 0, 0, 0,             0));
    // interrupt
    tbl.push_back(mk(0, 1, 12, 32'h401,      12, 0,             0, 0,  0, 0, 0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,             12, 32'h3010,      0, 0,  1, 0, 1, 0,             32'h401));
    tbl.push_back(mk(0, 0, 0, 0,             13, 0,             0, 0,  0, 0, 0, 32'h3010,      32'h400));
    tbl.push_back(mk(0, 0, 0, 0,             12, 0,             0, 0,  0, 0, 0, 32'h3010,      32'h403));
    // exception in delay slot
    tbl.push_back(mk(0, 1, 12, 0,            14, 0,             0, 0,  0, 0, 0, 32'h3010,      32'h3010));
    tbl.push_back(mk(0, 0, 0, 0,             12, 32'h3024,      1, 10, 0, 0, 1, 32'h3010,      0));
    tbl.push_back(mk(0, 0, 0, 0,             13, 0,             0, 0,  0, 0, 0, 32'h3020,      32'h8000_0028));
    tbl.push_back(mk(0, 0, 0, 0,             12, 0,             0, 0,  0, 0, 0, 32'h3020,      2));
    // simultaneous interrupt + exception + mtc0 EPC
    tbl.push_back(mk(0, 1, 12, 32'h801,      14, 0,             0, 0,  0, 0, 0, 32'h3020,      32'h3020));
    tbl.push_back(mk(0, 1, 14, 32'h1234,     12, 32'h3040,      0, 4,  2, 0, 1, 32'h3020,      32'h801));
    tbl.push_back(mk(0, 0, 0, 0,             13, 0,             0, 0,  0, 0, 0, 32'h3040,      32'h800));
    // eret with held IRQ, re-entry
    tbl.push_back(mk(0, 1, 12, 32'h403,      12, 0,             0, 0,  1, 0, 0, 32'h3040,      32'h803));
    tbl.push_back(mk(0, 0, 0, 0,             12, 0,             0, 0,  1, 1, 0, 32'h3040,      32'h403));
    tbl.push_back(mk(0, 0, 0, 0,             12, 32'h3100,      0, 0,  1, 0, 1, 32'h3040,      32'h401));
    tbl.push_back(mk(0, 0, 0, 0,             14, 0,             0, 0,  1, 0, 0, 32'h3100,      32'h3100));
    // masking, reads, read-only Cause
    tbl.push_back(mk(0, 1, 12, 1,            13, 0,             0, 0,  0, 0, 0, 32'h3100,      32'h400));
    tbl.push_back(mk(0, 0, 0, 0,             12, 0,             0, 0,  4, 0, 0, 32'h3100,      1));
    tbl.push_back(mk(0, 0, 0, 0,             13, 0,             0, 0,  4, 0, 0, 32'h3100,      32'h1000));
    tbl.push_back(mk(0, 0, 0, 0,             15, 0,             0, 0,  0, 0, 0, 32'h3100,      PRID));
    tbl.push_back(mk(0, 0, 0, 0,             7,  0,             0, 0,  0, 0, 0, 32'h3100,      0));
    tbl.push_back(mk(0, 1, 13, 32'hFFFF_FFFF,13, 0,             0, 0,  0, 0, 0, 32'h3100,      0));
    tbl.push_back(mk(0, 1, 15, 32'hFFFF_FFFF,13, 0,             0, 0,  0, 0, 0, 32'h3100,      0));
    tbl.push_back(mk(0, 0, 0, 0,             15, 0,             0, 0,  0, 0, 0, 32'h3100,      PRID));
    // VPC=0 in a delay slot wraps
    tbl.push_back(mk(0, 0, 0, 0,             14, 0,             1, 1,  0, 0, 1, 32'h3100,      32'h3100));
    tbl.push_back(mk(0, 0, 0, 0,             13, 0,             0, 0,  0, 0, 0, 32'hFFFF_FFFC, 32'h8000_0004));
    // reset mid-handler
    tbl.push_back(mk(0, 1, 14, 32'h3013,     12, 0,             0, 0,  0, 0, 0, 32'hFFFF_FFFC, 3));
    tbl.push_back(mk(0, 0, 0, 0,             14, 0,             0, 0,  1, 0, 0, 32'h3010,      32'h3010));
    tbl.push_back(mk(1, 0, 0, 0,             14, 0,             0, 0,  1, 0, 0, 32'h3010,      32'h3010));
    tbl.push_back(mk(0, 0, 0, 0,             13, 0,             0, 0,  1, 0, 0, 0,             0));
    tbl.push_back(mk(0, 0, 0, 0,             12, 0,             0, 0,  1, 0, 0, 0,             0));

    @(posedge clk); #1;
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);

    foreach (tbl[i]) cyc(tbl[i], 1, i);

    // Trap coinciding with eret: the trap wins and EXL ends up set.
    cyc(mk(0, 1, 12, 32'h401, 12, 0,        0, 0, 1, 0, 0, 0,        0),        1, 100);
    cyc(mk(0, 0, 0,  0,       12, 32'h3200, 0, 0, 1, 1, 1, 0,        32'h401),  1, 101);
    cyc(mk(0, 0, 0,  0,       12, 0,        0, 0, 0, 0, 0, 32'h3200, 32'h403),  1, 102);
    // mtc0 SR with EXL=1 in DIn alongside eret: EXL still clears.
    cyc(mk(0, 1, 12, 32'h403, 12, 0,        0, 0, 0, 1, 0, 32'h3200, 32'h403),  1, 103);
    cyc(mk(0, 0, 0,  0,       12, 0,        0, 0, 0, 0, 0, 32'h3200, 32'h401),  1, 104);

    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      v.rst = ($urandom_range(0, 59) == 0);
      v.we  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0: v.a2 = 5'd12;
        1: v.a2 = 5'd13;
        2: v.a2 = 5'd14;
        3: v.a2 = 5'd15;
        default: v.a2 = r[4:0];
      endcase
      v.din = $urandom;
      if ($urandom_range(0, 1) == 0) v.din[1] = 1'b0;
      v.a1  = ($urandom_range(0, 5) == 0) ? r[9:5] : 5'(12 + $urandom_range(0, 3));
      v.vpc = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      v.bd  = r[10];
      v.exc = ($urandom_range(0, 5) == 0) ? r[15:11] : 5'd0;
      v.hw  = {3'b000, r[18:16] & {3{r[19]}}};
      v.clr = ($urandom_range(0, 5) == 0);
      v.ereq = 1'b0; v.eepc = 32'd0; v.edout = 32'd0;
      cyc(v, 2, i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
